// File: rtl/disp_select_10_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_select_10_if
// Purpose  : Bus bundle for the 11-way disparity selector: correlation set
//            input with write strobe, winning disparity result with valid
//            pulse, confidence flag and busy indication.
// Revision : 1.0  initial release
// ============================================================================
interface disp_select_10_if #(
    parameter int unsigned sh_reg_w = 8  // 4'b1000
);
    logic                    wen;
    logic [2*sh_reg_w-1:0]   corr_in_0;
    logic [2*sh_reg_w-1:0]   corr_in_1;
    logic [2*sh_reg_w-1:0]   corr_in_2;
    logic [2*sh_reg_w-1:0]   corr_in_3;
    logic [2*sh_reg_w-1:0]   corr_in_4;
    logic [2*sh_reg_w-1:0]   corr_in_5;
    logic [2*sh_reg_w-1:0]   corr_in_6;
    logic [2*sh_reg_w-1:0]   corr_in_7;
    logic [2*sh_reg_w-1:0]   corr_in_8;
    logic [2*sh_reg_w-1:0]   corr_in_9;
    logic [2*sh_reg_w-1:0]   corr_in_10;
    logic [3:0]              disp_out;
    logic [2*sh_reg_w-1:0]   corr_max;
    logic                    dout_valid;
    logic                    dout_conf;
    logic                    busy;

    // Producer of correlation sets / consumer of results
    modport master (
        output wen,
        output corr_in_0, corr_in_1, corr_in_2, corr_in_3, corr_in_4, corr_in_5,
        output corr_in_6, corr_in_7, corr_in_8, corr_in_9, corr_in_10,
        input  disp_out, corr_max, dout_valid, dout_conf, busy
    );

    // The selector itself
    modport slave (
        input  wen,
        input  corr_in_0, corr_in_1, corr_in_2, corr_in_3, corr_in_4, corr_in_5,
        input  corr_in_6, corr_in_7, corr_in_8, corr_in_9, corr_in_10,
        output disp_out, corr_max, dout_valid, dout_conf, busy
    );
endinterface
`default_nettype wire

// File: rtl/disp_select_10.sv
`default_nettype none
// ============================================================================
// Module   : disp_select_10
// Purpose  : Captures a set of 11 correlation scores and scans them one per
//            cycle to find the disparity with the highest score (ties keep
//            the lower index). Result appears 11 edges after acceptance.
// Options  : DISP_THRESH_EN - when defined, dout_conf reports whether the
//            winning score reached THRESH; otherwise dout_conf is always 1.
// Revision : 1.0  initial release
// ============================================================================
module disp_select_10 #(
    parameter int unsigned               sh_reg_w = 8,       // 4'b1000
    parameter logic [2*sh_reg_w-1:0]     THRESH   = 16'd256
) (
    input  wire logic           clk,
    input  wire logic           rst,
    disp_select_10_if.slave     bus
);
    localparam int unsigned c_W        = 2 * sh_reg_w;
    localparam logic [3:0]  c_LAST_IDX = 4'd10;

`ifdef DISP_THRESH_EN
    localparam logic        c_CONF_FORCE = 1'b0;
`else
    localparam logic        c_CONF_FORCE = 1'b1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [c_W-1:0]   r_cap [0:10];
    logic [c_W-1:0]   r_run_max;
    logic [3:0]       r_run_idx;
    logic [3:0]       r_disp;
    logic [c_W-1:0]   r_corr_max;
    logic             r_valid;
    logic             r_conf;

    logic [c_W-1:0]   w_in [0:10];
    logic [c_W-1:0]   w_cand;
    logic             w_take;
    logic             w_conf;

    assign w_in[0]  = bus.corr_in_0;
    assign w_in[1]  = bus.corr_in_1;
    assign w_in[2]  = bus.corr_in_2;
    assign w_in[3]  = bus.corr_in_3;
    assign w_in[4]  = bus.corr_in_4;
    assign w_in[5]  = bus.corr_in_5;
    assign w_in[6]  = bus.corr_in_6;
    assign w_in[7]  = bus.corr_in_7;
    assign w_in[8]  = bus.corr_in_8;
    assign w_in[9]  = bus.corr_in_9;
    assign w_in[10] = bus.corr_in_10;

    // Strict compare so an equal score never displaces the lower index
    assign w_cand = r_cap[r_cnt];
    assign w_take = (w_cand > r_run_max);
    assign w_conf = c_CONF_FORCE | (r_run_max >= THRESH);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; wen only matters when idle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.wen) w_next = S_SCAN;
            S_SCAN:  if (r_cnt == c_LAST_IDX) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture, running-max scan and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= 10; i++) begin
                r_cap[i] <= '0;
            end
            r_cnt      <= 4'd0;
            r_run_max  <= '0;
            r_run_idx  <= 4'd0;
            r_disp     <= 4'd0;
            r_corr_max <= '0;
            r_valid    <= 1'b0;
            r_conf     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.wen) begin
                        for (int i = 0; i <= 10; i++) begin
                            r_cap[i] <= w_in[i];
                        end
                        r_run_max <= w_in[0];
                        r_run_idx <= 4'd0;
                        r_cnt     <= 4'd1;
                    end
                end
                S_SCAN: begin
                    if (w_take) begin
                        r_run_max <= w_cand;
                        r_run_idx <= r_cnt;
                    end
                    // Park at 0 after the last index so the counter stays in 0..10
                    if (r_cnt == c_LAST_IDX) begin
                        r_cnt <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_disp     <= r_run_idx;
                    r_corr_max <= r_run_max;
                    r_conf     <= w_conf;
                    r_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.disp_out   = r_disp;
    assign bus.corr_max   = r_corr_max;
    assign bus.dout_valid = r_valid;
    assign bus.dout_conf  = r_conf;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
